// File: rtl/aes_encrypt_iterative.sv
// rtl/aes_encrypt_iterative.sv - iterative AES-128 encryptor, one round per clock, on-the-fly key expansion
// Defining AES_ENC_LAST_KEY_EN adds the last_key output (final round key).

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] b;
    p = 8'h00;
    b = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ b;
      b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254 through an addition chain; a=0 naturally maps to 0.
  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
  assign x2   = gmul(a, a);
  assign x3   = gmul(x2, a);
  assign x6   = gmul(x3, x3);
  assign x12  = gmul(x6, x6);
  assign x15  = gmul(x12, x3);
  assign x30  = gmul(x15, x15);
  assign x60  = gmul(x30, x30);
  assign x120 = gmul(x60, x60);
  assign x240 = gmul(x120, x120);
  assign inv  = gmul(gmul(x240, x12), x2);

  assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_encrypt_iterative (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_in,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         ready_out,
  output logic         valid_output,
  output logic [127:0] ciphertext
`ifdef AES_ENC_LAST_KEY_EN
  ,
  output logic [127:0] last_key
`endif
);
  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t         fsm, fsm_next;
  logic [127:0] state_reg, rk_reg;
  logic [7:0]   rcon;
  logic [3:0]   round;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  // Key schedule: RotWord + SubWord on the last word, rcon into the top byte.
  logic [31:0]  w3_rot, w3_sub, ks_temp;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_rk;

  assign w3_rot = {rk_reg[23:0], rk_reg[31:24]};

  for (genvar k = 0; k < 4; k++) begin : g_ks_sbox
    aes_sbox u_sbox (.a(w3_rot[31-8*k -: 8]), .y(w3_sub[31-8*k -: 8]));
  end

  assign ks_temp = w3_sub ^ {rcon, 24'h000000};
  assign n0      = rk_reg[127:96] ^ ks_temp;
  assign n1      = rk_reg[95:64]  ^ n0;
  assign n2      = rk_reg[63:32]  ^ n1;
  assign n3      = rk_reg[31:0]   ^ n2;
  assign next_rk = {n0, n1, n2, n3};

  // Round datapath; byte i lives at bits [127-8i -: 8], i = row + 4*col.
  logic [127:0] sb, sr, mc, round_out;

  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes_sbox u_sbox (.a(state_reg[127-8*i -: 8]), .y(sb[127-8*i -: 8]));
  end

  for (genvar r = 0; r < 4; r++) begin : g_shift_row
    for (genvar c = 0; c < 4; c++) begin : g_shift_col
      localparam int DST = r + 4*c;
      localparam int SRC = r + 4*((c + r) % 4);
      assign sr[127-8*DST -: 8] = sb[127-8*SRC -: 8];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
  end

  assign round_out = ((round == 4'd10) ? sr : mc) ^ next_rk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsm <= IDLE;
    else       fsm <= fsm_next;
  end

  always_comb begin
    fsm_next  = fsm;
    ready_out = 1'b0;
    case (fsm)
      IDLE: begin
        ready_out = 1'b1;
        if (valid_in) fsm_next = RUN;
      end
      RUN: begin
        if (round == 4'd10) fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= '0;
      rk_reg       <= '0;
      rcon         <= 8'h00;
      round        <= 4'd0;
      ciphertext   <= '0;
      valid_output <= 1'b0;
`ifdef AES_ENC_LAST_KEY_EN
      last_key     <= '0;
`endif
    end else begin
      valid_output <= 1'b0;
      if (fsm == IDLE) begin
        if (valid_in) begin
          state_reg <= plaintext ^ key;
          rk_reg    <= key;
          round     <= 4'd1;
          rcon      <= 8'h01;
        end
      end else begin
        state_reg <= round_out;
        rk_reg    <= next_rk;
        rcon      <= xt(rcon);
        if (round == 4'd10) begin
          round        <= 4'd0;
          ciphertext   <= round_out;
          valid_output <= 1'b1;
`ifdef AES_ENC_LAST_KEY_EN
          last_key     <= next_rk;
`endif
        end else begin
          round <= round + 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_aes_encrypt_iterative.sv
// tb/tb_aes_encrypt_iterative.sv - self-checking bench for aes_encrypt_iterative against a byte-level AES model
// Last-key checks are compiled in when AES_ENC_LAST_KEY_EN is defined.

module tb_aes_encrypt_iterative;
  logic         clk = 1'b0;
  logic         reset;
  logic         valid_in;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         ready_out;
  logic         valid_output;
  logic [127:0] ciphertext;
`ifdef AES_ENC_LAST_KEY_EN
  logic [127:0] last_key;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] sbox_t [256];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_LK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] Z_LK   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] RT_PT  = 128'h00000101030307070f0f1f1f3f3f7f7f;
  localparam logic [127:0] RT_CT  = 128'hc7d12419489e3b6233a2c5a7f4563172;

  always #5 clk = ~clk;

  aes_encrypt_iterative dut (
    .clk(clk),
    .reset(reset),
    .valid_in(valid_in),
    .plaintext(plaintext),
    .key(key),
    .ready_out(ready_out),
    .valid_output(valid_output),
    .ciphertext(ciphertext)
`ifdef AES_ENC_LAST_KEY_EN
    ,
    .last_key(last_key)
`endif
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box table from the generator-3 walk: p runs over powers of 3, q over powers of 1/3.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ xt(p);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic void aes_model(input logic [127:0] pt, input logic [127:0] k,
                                    output logic [127:0] ct, output logic [127:0] lk);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] rk;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]}
              ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          s[row + 4*col] = t[row + 4*((col + row) % 4)];
      if (r < 10) begin
        for (int col = 0; col < 4; col++) begin
          a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
          s[4*col]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*col+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*col+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*col+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    lk = {w[40], w[41], w[42], w[43]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one accept and returns cycles until valid_output (-1 if none within 20).
  task automatic run_block(input logic [127:0] pt, input logic [127:0] k, output int lat);
    @(negedge clk);
    plaintext = pt;
    key       = k;
    valid_in  = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (valid_output === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b0; plaintext = '0; key = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_out); end
    checks++; if (valid_output !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_output); end
    checks++; if (ciphertext !== 128'h0) begin errors++; $display("FAIL reset_ct: got %h expected 0", ciphertext); end
`ifdef AES_ENC_LAST_KEY_EN
    checks++; if (last_key !== 128'h0) begin errors++; $display("FAIL reset_lk: got %h expected 0", last_key); end
`endif
  endtask

  task automatic test_vectors();
    logic [127:0] pts [3];
    logic [127:0] keys [3];
    logic [127:0] cts [3];
    logic [127:0] lks [3];
    logic [127:0] mct, mlk;
    int lat;
    pts[0] = C1_PT; keys[0] = C1_KEY; cts[0] = C1_CT; lks[0] = C1_LK;
    pts[1] = '0;    keys[1] = '0;     cts[1] = Z_CT;  lks[1] = Z_LK;
    pts[2] = RT_PT; keys[2] = '0;     cts[2] = RT_CT; lks[2] = Z_LK;
    for (int v = 0; v < 3; v++) begin
      aes_model(pts[v], keys[v], mct, mlk);
      checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL vec%0d_ready: got %b expected 1", v, ready_out); end
      run_block(pts[v], keys[v], lat);
      checks++; if (lat != 10) begin errors++; $display("FAIL vec%0d_latency: got %0d expected 10", v, lat); end
      checks++; if (ciphertext !== cts[v]) begin errors++; $display("FAIL vec%0d_ct: got %h expected %h", v, ciphertext, cts[v]); end
`ifdef AES_ENC_LAST_KEY_EN
      checks++; if (last_key !== lks[v]) begin errors++; $display("FAIL vec%0d_lk: got %h expected %h", v, last_key, lks[v]); end
`endif
      @(posedge clk); #1;
      checks++; if (valid_output !== 1'b0) begin errors++; $display("FAIL vec%0d_strobe_width: got %b expected 0", v, valid_output); end
      checks++; if (ciphertext !== mct) begin errors++; $display("FAIL vec%0d_ct_held: got %h expected %h", v, ciphertext, mct); end
    end
  endtask

  task automatic test_random();
    logic [127:0] pt, k, mct, mlk;
    int lat;
    for (int n = 0; n < 6; n++) begin
      pt = rand128();
      k  = rand128();
      aes_model(pt, k, mct, mlk);
      run_block(pt, k, lat);
      checks++; if (lat != 10) begin errors++; $display("FAIL rand%0d_latency: got %0d expected 10", n, lat); end
      checks++; if (ciphertext !== mct) begin errors++; $display("FAIL rand%0d_ct: got %h expected %h", n, ciphertext, mct); end
`ifdef AES_ENC_LAST_KEY_EN
      checks++; if (last_key !== mlk) begin errors++; $display("FAIL rand%0d_lk: got %h expected %h", n, last_key, mlk); end
`endif
    end
  endtask

  task automatic test_busy();
    int pulses, first, bad_ready;
    pulses = 0; first = -1; bad_ready = 0;
    @(negedge clk);
    plaintext = C1_PT; key = C1_KEY; valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      if (valid_output === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
      end
      if (c < 10 && ready_out !== 1'b0) bad_ready++;
      if (c == 3 || c == 7) begin
        checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL busy_ready_c%0d: got %b expected 0", c, ready_out); end
        plaintext = rand128();
        key       = rand128();
        valid_in  = 1'b1;
      end else begin
        valid_in = 1'b0;
      end
    end
    checks++; if (bad_ready != 0) begin errors++; $display("FAIL busy_ready_run: got %0d high cycles expected 0", bad_ready); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL busy_pulses: got %0d expected 1", pulses); end
    checks++; if (first != 10) begin errors++; $display("FAIL busy_latency: got %0d expected 10", first); end
    checks++; if (ciphertext !== C1_CT) begin errors++; $display("FAIL busy_ct: got %h expected %h", ciphertext, C1_CT); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] got_ct [2];
    int got_t [2];
    int pulses;
    logic [127:0] zct, zlk;
    aes_model('0, '0, zct, zlk);
    pulses = 0;
    got_t[0] = -1; got_t[1] = -1; got_ct[0] = '0; got_ct[1] = '0;
    @(negedge clk);
    plaintext = C1_PT; key = C1_KEY; valid_in = 1'b1;
    @(posedge clk);
    #1 plaintext = '0; key = '0;
    for (int c = 1; c <= 26; c++) begin
      @(posedge clk);
      #1;
      if (valid_output === 1'b1) begin
        if (pulses < 2) begin
          got_t[pulses]  = c;
          got_ct[pulses] = ciphertext;
        end
        pulses++;
      end
      if (c == 21) valid_in = 1'b0;
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
    checks++; if (got_t[0] != 10) begin errors++; $display("FAIL b2b_first_time: got %0d expected 10", got_t[0]); end
    checks++; if (got_t[1] != 21) begin errors++; $display("FAIL b2b_second_time: got %0d expected 21", got_t[1]); end
    checks++; if (got_ct[0] !== C1_CT) begin errors++; $display("FAIL b2b_first_ct: got %h expected %h", got_ct[0], C1_CT); end
    checks++; if (got_ct[1] !== zct) begin errors++; $display("FAIL b2b_second_ct: got %h expected %h", got_ct[1], zct); end
  endtask

  task automatic test_reset_mid_run();
    int pulses, lat;
    pulses = 0;
    @(negedge clk);
    plaintext = C1_PT; key = C1_KEY; valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", ready_out); end
    checks++; if (valid_output !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", valid_output); end
    checks++; if (ciphertext !== 128'h0) begin errors++; $display("FAIL midrst_ct: got %h expected 0", ciphertext); end
`ifdef AES_ENC_LAST_KEY_EN
    checks++; if (last_key !== 128'h0) begin errors++; $display("FAIL midrst_lk: got %h expected 0", last_key); end
`endif
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (valid_output === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_no_pulse: got %0d expected 0", pulses); end
    run_block(C1_PT, C1_KEY, lat);
    checks++; if (lat != 10) begin errors++; $display("FAIL midrst_after_latency: got %0d expected 10", lat); end
    checks++; if (ciphertext !== C1_CT) begin errors++; $display("FAIL midrst_after_ct: got %h expected %h", ciphertext, C1_CT); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    test_reset();
    test_vectors();
    test_random();
    test_busy();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
